// File: rtl/ttc_gen.sv
// TTC command generator: free-running LHC bunch/orbit counters with BC0, resync
// and spacing-checked L1A strobes, all registered.
module ttc_gen #(
  parameter int                MXBXN        = 12,
  parameter logic [MXBXN-1:0]  LHC_CYCLE    = 12'd3564,
  parameter int                MXCNT        = 32,
  parameter int                L1A_MIN_GAP  = 4,
  parameter int                RESYNC_QUIET = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [MXBXN-1:0] bx0_phase,
  input  logic             resync_req,
  input  logic [MXBXN-1:0] resync_bx,
  input  logic             l1a_req,
  output logic             ttc_bx0,
  output logic             ttc_resync,
  output logic             ttc_l1a,
  output logic             resync_busy,
  output logic             l1a_drop,
  output logic [MXBXN-1:0] gen_bxn,
  output logic [MXCNT-1:0] gen_orbit,
  output logic [MXCNT-1:0] l1a_count
);

  localparam int GW = $clog2(L1A_MIN_GAP + 1);
  localparam int QW = (RESYNC_QUIET > 1) ? $clog2(RESYNC_QUIET) : 1;
  localparam logic [MXBXN-1:0] BXN_LAST   = MXBXN'(LHC_CYCLE - 1);
  localparam logic [GW-1:0]    GAP_MAX    = GW'(L1A_MIN_GAP);
  localparam logic [QW-1:0]    QUIET_LAST = QW'(RESYNC_QUIET - 1);

  typedef enum logic [1:0] {IDLE, RUN, RS_WAIT, RS_QUIET} state_t;

  state_t           state;
  logic [MXBXN-1:0] bx0_phase_r;
  logic [MXBXN-1:0] resync_bx_r;
  logic [GW-1:0]    gap_cnt;
  logic [QW-1:0]    quiet_cnt;

  logic [MXBXN-1:0] bx0_clip;
  logic [MXBXN-1:0] resync_clip;
  logic             bx0_hit;
  logic             rs_hit;
  logic             l1a_ok;

  always_comb begin
    bx0_clip    = (bx0_phase >= LHC_CYCLE) ? BXN_LAST : bx0_phase;
    resync_clip = (resync_bx >= LHC_CYCLE) ? BXN_LAST : resync_bx;
    bx0_hit     = (gen_bxn == bx0_phase_r);
    rs_hit      = (state == RS_WAIT) && (gen_bxn == resync_bx_r);
    // The clock that commits to RS_QUIET cannot accept an L1A: its strobe
    // would land inside the quiet window.
    l1a_ok      = (gap_cnt >= GAP_MAX) &&
                  ((state == RUN) || ((state == RS_WAIT) && !rs_hit));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bx0_phase_r <= '0;
      resync_bx_r <= '0;
      gap_cnt     <= '0;
      quiet_cnt   <= '0;
      gen_bxn     <= '0;
      gen_orbit   <= '0;
      l1a_count   <= '0;
      ttc_bx0     <= 1'b0;
      ttc_resync  <= 1'b0;
      ttc_l1a     <= 1'b0;
      resync_busy <= 1'b0;
      l1a_drop    <= 1'b0;
    end else begin
      bx0_phase_r <= bx0_clip;
      resync_bx_r <= resync_clip;
      ttc_bx0     <= 1'b0;
      ttc_resync  <= 1'b0;
      ttc_l1a     <= 1'b0;
      l1a_drop    <= 1'b0;

      if (!enable) begin
        state       <= IDLE;
        gen_bxn     <= '0;
        resync_busy <= 1'b0;
        gap_cnt     <= '0;
        quiet_cnt   <= '0;
        l1a_drop    <= l1a_req;
      end else begin
        if (state != IDLE) begin
          if (gen_bxn == BXN_LAST) begin
            gen_bxn <= '0;
            if (gen_orbit != '1) gen_orbit <= gen_orbit + 1'b1;
          end else begin
            gen_bxn <= gen_bxn + 1'b1;
          end
        end

        if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;

        if (l1a_req) begin
          if (l1a_ok) begin
            ttc_l1a <= 1'b1;
            gap_cnt <= GW'(1);
            if (l1a_count != '1) l1a_count <= l1a_count + 1'b1;
          end else begin
            l1a_drop <= 1'b1;
          end
        end

        // Later assignments in this case override the free-running updates above.
        case (state)
          IDLE: begin
            state   <= RUN;
            gap_cnt <= '0;
          end
          RUN: begin
            ttc_bx0 <= bx0_hit;
            if (resync_req) begin
              state       <= RS_WAIT;
              resync_busy <= 1'b1;
            end
          end
          RS_WAIT: begin
            if (rs_hit) begin
              state      <= RS_QUIET;
              ttc_resync <= 1'b1;
              gen_bxn    <= '0;
              gen_orbit  <= '0;
              l1a_count  <= '0;
              quiet_cnt  <= '0;
            end else begin
              ttc_bx0 <= bx0_hit;
            end
          end
          RS_QUIET: begin
            if (quiet_cnt == QUIET_LAST) begin
              state       <= RUN;
              resync_busy <= 1'b0;
              gap_cnt     <= '0;
            end else begin
              quiet_cnt <= quiet_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
